vga_timing_xga: RTL and testbench

Free-running XGA 1024x768 @ 60 Hz raster timing generator that drives the head of the display pipeline. It produces the `hcount`/`vcount`/`hsync`/`hblnk`/`vsync`/`vblnk` stream that every downstream draw stage (background, grid, square overlays, marks) consumes and re-registers. All outputs are registered and mutually aligned, so the first draw stage sees a consistent pixel coordinate and its sync/blank flags in the same cycle. It also emits a one-cycle frame tick and an 8-bit frame counter for game-logic animation and debouncing.

---
 rtl/vga_timing_xga.sv | 118 +++++++++++
 tb/tb_vga_timing_xga.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_xga.sv
// rtl/vga_timing_xga.sv - XGA 1024x768@60 raster timing generator with frame tick and counter
module vga_timing_xga #(
    parameter int H_ACTIVE = 1024,
    parameter int H_FP     = 24,
    parameter int H_SYNC   = 136,
    parameter int H_BP     = 160,
    parameter int V_ACTIVE = 768,
    parameter int V_FP     = 3,
    parameter int V_SYNC   = 6,
    parameter int V_BP     = 29
) (
    input  logic        pclk,
    input  logic        rst_n,
    input  logic        en,
    output logic [10:0] hcount_out,
    output logic [10:0] vcount_out,
    output logic        hsync_out,
    output logic        hblnk_out,
    output logic        vsync_out,
    output logic        vblnk_out,
    output logic        frame_tick,
    output logic [7:0]  frame_cnt
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    // Counter limits and decode thresholds, sized to the 11-bit counters
    localparam logic [10:0] H_LAST     = 11'(H_TOTAL - 1);
    localparam logic [10:0] V_LAST     = 11'(V_TOTAL - 1);
    localparam logic [10:0] H_BLNK_BEG = 11'(H_ACTIVE);
    localparam logic [10:0] H_SYNC_BEG = 11'(H_ACTIVE + H_FP);
    localparam logic [10:0] H_SYNC_END = 11'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [10:0] V_BLNK_BEG = 11'(V_ACTIVE);
    localparam logic [10:0] V_SYNC_BEG = 11'(V_ACTIVE + V_FP);
    localparam logic [10:0] V_SYNC_END = 11'(V_ACTIVE + V_FP + V_SYNC);

    // Totals must be representable by the 11-bit counters (max count 2047)
    generate
        if (H_TOTAL > 2048 || V_TOTAL > 2048 || H_TOTAL < 1 || V_TOTAL < 1) begin : g_size_check
            $error("vga_timing_xga: H_TOTAL/V_TOTAL out of 11-bit range");
        end
    endgenerate

    logic [10:0] h_next;
    logic [10:0] v_next;
    logic        frame_wrap;
    logic        hsync_next;
    logic        hblnk_next;
    logic        vsync_next;
    logic        vblnk_next;

    // Next raster position; line and frame wrap resolve in the same step
    always_comb begin
        h_next     = hcount_out;
        v_next     = vcount_out;
        frame_wrap = 1'b0;
        if (hcount_out == H_LAST) begin
            h_next = 11'd0;
            if (vcount_out == V_LAST) begin
                v_next     = 11'd0;
                frame_wrap = 1'b1;
            end else begin
                v_next = vcount_out + 11'd1;
            end
        end else begin
            h_next = hcount_out + 11'd1;
        end
    end

    // Flags decoded from the next position so they register alongside the counters
    always_comb begin
        hblnk_next = (h_next >= H_BLNK_BEG);
        hsync_next = (h_next >= H_SYNC_BEG) && (h_next < H_SYNC_END);
        vblnk_next = (v_next >= V_BLNK_BEG);
        vsync_next = (v_next >= V_SYNC_BEG) && (v_next < V_SYNC_END);
    end

    // Raster position registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hcount_out <= 11'd0;
            vcount_out <= 11'd0;
        end else if (en) begin
            hcount_out <= h_next;
            vcount_out <= v_next;
        end
    end

    // Sync and blank registers, aligned with the position registers
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_out <= 1'b0;
            hblnk_out <= 1'b0;
            vsync_out <= 1'b0;
            vblnk_out <= 1'b0;
        end else if (en) begin
            hsync_out <= hsync_next;
            hblnk_out <= hblnk_next;
            vsync_out <= vsync_next;
            vblnk_out <= vblnk_next;
        end
    end

    // Frame tick marks (0,0) reached by wrapping only; it holds while en is low
    always_ff @(posedge pclk or negedge rst_n) begin
        if (!rst_n) begin
            frame_tick <= 1'b0;
            frame_cnt  <= 8'd0;
        end else if (en) begin
            frame_tick <= frame_wrap;
            if (frame_wrap) begin
                frame_cnt <= frame_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_vga_timing_xga.sv
// tb/tb_vga_timing_xga.sv - scoreboard bench for vga_timing_xga (XGA and shrunk raster)
module tb_vga_timing_xga;

    typedef logic [34:0] vec_t;

    // Instance 0 uses XGA defaults, instance 1 a small raster (16 x 10) for frame-level checks
    localparam int HA  [2] = '{1024, 8};
    localparam int HFP [2] = '{24, 2};
    localparam int HSW [2] = '{136, 3};
    localparam int HBP [2] = '{160, 3};
    localparam int VA  [2] = '{768, 6};
    localparam int VFP [2] = '{3, 1};
    localparam int VSW [2] = '{6, 2};
    localparam int VBP [2] = '{29, 1};

    logic pclk = 1'b0;
    always #5 pclk = ~pclk;

    logic rst_a, en_a, rst_b, en_b;
    logic [10:0] hc_a, vc_a, hc_b, vc_b;
    logic hs_a, hb_a, vs_a, vb_a, ft_a;
    logic hs_b, hb_b, vs_b, vb_b, ft_b;
    logic [7:0] fc_a, fc_b;

    vga_timing_xga dut_a (
        .pclk(pclk), .rst_n(rst_a), .en(en_a),
        .hcount_out(hc_a), .vcount_out(vc_a),
        .hsync_out(hs_a), .hblnk_out(hb_a), .vsync_out(vs_a), .vblnk_out(vb_a),
        .frame_tick(ft_a), .frame_cnt(fc_a)
    );

    vga_timing_xga #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(3),
        .V_ACTIVE(6), .V_FP(1), .V_SYNC(2), .V_BP(1)
    ) dut_b (
        .pclk(pclk), .rst_n(rst_b), .en(en_b),
        .hcount_out(hc_b), .vcount_out(vc_b),
        .hsync_out(hs_b), .hblnk_out(hb_b), .vsync_out(vs_b), .vblnk_out(vb_b),
        .frame_tick(ft_b), .frame_cnt(fc_b)
    );

    int total = 0;
    int bad = 0;
    int mh [2];
    int mv [2];
    int mt [2];
    int mc [2];
    vec_t sb[$];

    function automatic vec_t model_vec(input int i);
        logic hs, hb, vs, vb;
        hb = (mh[i] >= HA[i]);
        hs = (mh[i] >= HA[i] + HFP[i]) && (mh[i] < HA[i] + HFP[i] + HSW[i]);
        vb = (mv[i] >= VA[i]);
        vs = (mv[i] >= VA[i] + VFP[i]) && (mv[i] < VA[i] + VFP[i] + VSW[i]);
        return {11'(mh[i]), 11'(mv[i]), hs, hb, vs, vb, mt[i] != 0, 8'(mc[i])};
    endfunction

    function automatic vec_t dut_vec(input int i);
        if (i == 0) return {hc_a, vc_a, hs_a, hb_a, vs_a, vb_a, ft_a, fc_a};
        return {hc_b, vc_b, hs_b, hb_b, vs_b, vb_b, ft_b, fc_b};
    endfunction

    task automatic model_reset(input int i);
        mh[i] = 0; mv[i] = 0; mt[i] = 0; mc[i] = 0;
    endtask

    task automatic model_step(input int i, input bit e);
        int t;
        if (e) begin
            t = 0;
            if (mh[i] == HA[i] + HFP[i] + HSW[i] + HBP[i] - 1) begin
                mh[i] = 0;
                if (mv[i] == VA[i] + VFP[i] + VSW[i] + VBP[i] - 1) begin
                    mv[i] = 0;
                    t = 1;
                    mc[i] = (mc[i] + 1) % 256;
                end else begin
                    mv[i] = mv[i] + 1;
                end
            end else begin
                mh[i] = mh[i] + 1;
            end
            mt[i] = t;
        end
    endtask

    // One pclk on instance i; the other instance is frozen so its model stays valid
    task automatic tick(input int i, input bit e, input string tag);
        vec_t exp_v, act_v;
        en_a = (i == 0) ? e : 1'b0;
        en_b = (i == 1) ? e : 1'b0;
        model_step(i, e);
        sb.push_back(model_vec(i));
        @(posedge pclk);
        @(negedge pclk);
        exp_v = sb.pop_front();
        act_v = dut_vec(i);
        total++;
        if (act_v !== exp_v) begin
            bad++;
            $display("FAIL %s inst%0d got=%h want=%h", tag, i, act_v, exp_v);
        end
    endtask

    task automatic test_reset();
        rst_a = 1'b0; rst_b = 1'b0; en_a = 1'b1; en_b = 1'b1;
        model_reset(0); model_reset(1);
        repeat (3) @(negedge pclk);
        total++;
        if (dut_vec(0) !== 35'd0) begin
            bad++; $display("FAIL reset_a got=%h want=0", dut_vec(0));
        end
        total++;
        if (dut_vec(1) !== 35'd0) begin
            bad++; $display("FAIL reset_b got=%h want=0", dut_vec(1));
        end
        rst_a = 1'b1; rst_b = 1'b1; en_a = 1'b0; en_b = 1'b0;
    endtask

    task automatic test_line_a();
        int cnt, first;
        tick(0, 1'b1, "first_edge");
        total++;
        if (hc_a !== 11'd1 || vc_a !== 11'd0 || {hs_a, hb_a, vs_a, vb_a, ft_a} !== 5'd0) begin
            bad++; $display("FAIL first_edge got h=%0d v=%0d", hc_a, vc_a);
        end
        repeat (1023) tick(0, 1'b1, "to_active_end");
        total++;
        if (hc_a !== 11'd1024 || hb_a !== 1'b1) begin
            bad++; $display("FAIL hblnk_rise got h=%0d hb=%b want h=1024 hb=1", hc_a, hb_a);
        end
        cnt = 0; first = -1;
        for (int k = 1025; k <= 1343; k++) begin
            tick(0, 1'b1, "hblank_run");
            if (hs_a === 1'b1) begin
                cnt++;
                if (first < 0) first = hc_a;
            end
        end
        total++;
        if (cnt != 136 || first != 1048) begin
            bad++; $display("FAIL hsync_window got len=%0d start=%0d want 136/1048", cnt, first);
        end
        tick(0, 1'b1, "line_wrap");
        total++;
        if (hc_a !== 11'd0 || vc_a !== 11'd1) begin
            bad++; $display("FAIL line_wrap got h=%0d v=%0d want 0/1", hc_a, vc_a);
        end
    endtask

    task automatic test_en_gate_a();
        repeat (500) tick(0, 1'b1, "to_500");
        repeat (10) tick(0, 1'b0, "frozen");
        total++;
        if (hc_a !== 11'd500 || vc_a !== 11'd1) begin
            bad++; $display("FAIL en_freeze got h=%0d want 500", hc_a);
        end
        tick(0, 1'b1, "resume");
        total++;
        if (hc_a !== 11'd501) begin
            bad++; $display("FAIL en_resume got h=%0d want 501", hc_a);
        end
    endtask

    task automatic test_frame_b();
        int nvb, nvs, tick_at, enabled, guard;
        bit e;
        nvb = 0; nvs = 0; tick_at = -1;
        for (int k = 1; k <= 160; k++) begin
            tick(1, 1'b1, "frame1");
            if (vb_b === 1'b1) nvb++;
            if (vs_b === 1'b1) nvs++;
            if (ft_b === 1'b1 && tick_at < 0) tick_at = k;
        end
        total++;
        if (nvb != 64 || nvs != 32) begin
            bad++; $display("FAIL v_flags got vblnk=%0d vsync=%0d want 64/32", nvb, nvs);
        end
        total++;
        if (tick_at != 160 || fc_b !== 8'd1 || hc_b !== 11'd0 || vc_b !== 11'd0) begin
            bad++; $display("FAIL first_tick got at=%0d cnt=%0d want 160/1", tick_at, fc_b);
        end
        repeat (3) tick(1, 1'b0, "tick_hold");
        total++;
        if (ft_b !== 1'b1) begin
            bad++; $display("FAIL tick_hold got=%b want=1", ft_b);
        end
        tick(1, 1'b1, "tick_drop");
        total++;
        if (ft_b !== 1'b0) begin
            bad++; $display("FAIL tick_drop got=%b want=0", ft_b);
        end
        enabled = 1; guard = 0;
        while (guard < 2000) begin
            e = ($urandom_range(0, 3) != 0);
            tick(1, e, "gated_frame");
            guard++;
            if (e) begin
                enabled++;
                if (ft_b === 1'b1) break;
            end
        end
        total++;
        if (enabled != 160 || fc_b !== 8'd2 || guard >= 2000) begin
            bad++; $display("FAIL gated_frame_len got=%0d cnt=%0d want 160/2", enabled, fc_b);
        end
    endtask

    task automatic test_cnt_wrap_b();
        for (int f = 3; f <= 256; f++) begin
            repeat (160) tick(1, 1'b1, "frames");
            total++;
            if (fc_b !== 8'(f) || ft_b !== 1'b1) begin
                bad++; $display("FAIL frame_cnt got=%0d tick=%b want %0d/1", fc_b, ft_b, f % 256);
            end
        end
    endtask

    task automatic test_async_reset_b();
        int nt;
        repeat (69) tick(1, 1'b1, "to_mid");
        total++;
        if (hc_b !== 11'd5 || vc_b !== 11'd4) begin
            bad++; $display("FAIL mid_pos got h=%0d v=%0d want 5/4", hc_b, vc_b);
        end
        #2 rst_b = 1'b0;
        #1;
        model_reset(1);
        total++;
        if (dut_vec(1) !== 35'd0) begin
            bad++; $display("FAIL async_reset got=%h want=0", dut_vec(1));
        end
        @(negedge pclk);
        rst_b = 1'b1;
        nt = 0;
        repeat (159) begin
            tick(1, 1'b1, "post_reset");
            if (ft_b === 1'b1) nt++;
        end
        total++;
        if (nt != 0) begin
            bad++; $display("FAIL no_reset_tick got=%0d ticks want=0", nt);
        end
        tick(1, 1'b1, "post_reset_wrap");
        total++;
        if (ft_b !== 1'b1 || fc_b !== 8'd1) begin
            bad++; $display("FAIL restart_tick got tick=%b cnt=%0d want 1/1", ft_b, fc_b);
        end
    endtask

    initial begin
        test_reset();
        test_line_a();
        test_en_gate_a();
        test_frame_b();
        test_cnt_wrap_b();
        test_async_reset_b();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
